// File: rtl/snd_mix_pkg.sv
// Shared types, widths and helpers for the FM/PCM sound mixer.
package snd_mix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FML,
        ST_FMR,
        ST_PCM,
        ST_SAT
    } state_t;

    localparam int unsigned SMP_W  = 16;
    localparam int unsigned PROD_W = 20;
    localparam int unsigned SUM_W  = 21;

    localparam logic [SMP_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [SMP_W-1:0] SAT_MIN = 16'h8000;

    typedef struct packed {
        logic [SMP_W-1:0] left;
        logic [SMP_W-1:0] right;
    } fm_pair_t;

    // Offset-binary 8-bit PCM to signed 16-bit, silence (0x80) maps to zero.
    function automatic logic [SMP_W-1:0] pcm_to_s16(input logic [7:0] p);
        return {~p[7], p[6:0], 8'h00};
    endfunction

    // Clamp a shifted sum to 16 bits; MSB of the result is the clip flag.
    function automatic logic [SMP_W:0] sat_s16(input logic signed [SUM_W-1:0] v);
        if ((&v[SUM_W-1:SMP_W-1]) || !(|v[SUM_W-1:SMP_W-1]))
            return {1'b0, v[SMP_W-1:0]};
        else if (v[SUM_W-1])
            return {1'b1, SAT_MIN};
        else
            return {1'b1, SAT_MAX};
    endfunction

endpackage

// File: rtl/snd_mix_smul.sv
// Serial shift-add multiplier: signed 16-bit sample times unsigned gain, one gain bit per step.
module snd_mix_smul
    import snd_mix_pkg::*;
#(
    parameter int unsigned GW = 4,
    parameter int unsigned PW = PROD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step,
    input  logic                 start,
    input  logic signed [15:0]   a,
    input  logic [GW-1:0]        b,
    output logic signed [PW-1:0] prod
);

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] sh;
    logic [GW-1:0]        bits;

    assign a_ext = PW'(a);

    // LSB-first: the start step consumes b[0], later steps consume the shifted remainder.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod <= '0;
            sh   <= '0;
            bits <= '0;
        end else if (step) begin
            if (start) begin
                prod <= b[0] ? a_ext : '0;
                sh   <= a_ext <<< 1;
                bits <= b >> 1;
            end else begin
                prod <= bits[0] ? prod + sh : prod;
                sh   <= sh <<< 1;
                bits <= bits >> 1;
            end
        end
    end

endmodule

// File: rtl/snd_mix.sv
// FM + PCM mixer feeding the sigma-delta DACs; one time-shared serial multiplier per sample.
module snd_mix
    import snd_mix_pkg::*;
#(
    parameter int unsigned GW  = 4,
    parameter int unsigned GSH = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   fm_left,
    input  logic [15:0]   fm_right,
    input  logic          fm_sample,
    input  logic [7:0]    pcm,
    input  logic          pcm_sample,
    input  logic [GW-1:0] fm_gain,
    input  logic [GW-1:0] pcm_gain,
    output logic [15:0]   ldatasum,
    output logic [15:0]   rdatasum,
    output logic          out_valid,
    output logic          clip_l,
    output logic          clip_r,
    output logic          overrun
);

    localparam int unsigned CW = (GW > 1) ? $clog2(GW) : 1;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [7:0]           pcm_hold;
    fm_pair_t             w_fm, p_fm;
    logic [GW-1:0]        w_fg, w_pg, p_fg, p_pg;
    logic [7:0]           w_pcm;
    logic                 pending;
    logic signed [PROD_W-1:0] acc_l, acc_r, prod;
    logic [15:0]          stg_l, stg_r;
    logic                 stg_cl, stg_cr, stg_v;

    logic                 last_c, start_c, mul_step_c, mul_start_c;
    logic signed [15:0]   mul_a_c;
    logic [GW-1:0]        mul_b_c;
    logic signed [SUM_W-1:0] sum_l_c, sum_r_c;
    logic [16:0]          sat_l_c, sat_r_c;

    assign last_c      = (cnt == CW'(GW - 1));
    assign mul_start_c = (cnt == '0);
    assign start_c     = ((state == ST_IDLE) && (fm_sample || pending)) ||
                         ((state == ST_SAT) && pending);

    // Multiplier operand select: left FM, right FM, then the shared PCM term.
    always_comb begin
        mul_a_c    = w_fm.left;
        mul_b_c    = w_fg;
        mul_step_c = 1'b0;
        unique case (state)
            ST_FML: mul_step_c = 1'b1;
            ST_FMR: begin
                mul_a_c    = w_fm.right;
                mul_step_c = 1'b1;
            end
            ST_PCM: begin
                mul_a_c    = pcm_to_s16(w_pcm);
                mul_b_c    = w_pg;
                mul_step_c = 1'b1;
            end
            default: ;
        endcase
    end

    snd_mix_smul #(
        .GW (GW),
        .PW (PROD_W)
    ) u_smul (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (mul_step_c),
        .start (mul_start_c),
        .a     (mul_a_c),
        .b     (mul_b_c),
        .prod  (prod)
    );

    // In SAT the PCM product is still on prod and is added to both channels.
    assign sum_l_c = SUM_W'(acc_l) + SUM_W'(prod);
    assign sum_r_c = SUM_W'(acc_r) + SUM_W'(prod);
    assign sat_l_c = sat_s16(sum_l_c >>> GSH);
    assign sat_r_c = sat_s16(sum_r_c >>> GSH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pcm_hold  <= 8'h80;
            w_fm      <= '0;
            w_fg      <= '0;
            w_pg      <= '0;
            w_pcm     <= 8'h80;
            p_fm      <= '0;
            p_fg      <= '0;
            p_pg      <= '0;
            pending   <= 1'b0;
            overrun   <= 1'b0;
            acc_l     <= '0;
            acc_r     <= '0;
            stg_l     <= '0;
            stg_r     <= '0;
            stg_cl    <= 1'b0;
            stg_cr    <= 1'b0;
            stg_v     <= 1'b0;
            ldatasum  <= '0;
            rdatasum  <= '0;
            clip_l    <= 1'b0;
            clip_r    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            stg_v     <= 1'b0;
            out_valid <= stg_v;
            if (pcm_sample) pcm_hold <= pcm;
            if (stg_v) begin
                ldatasum <= stg_l;
                rdatasum <= stg_r;
                clip_l   <= stg_cl;
                clip_r   <= stg_cr;
            end

            unique case (state)
                ST_FML, ST_FMR, ST_PCM: begin
                    cnt <= last_c ? '0 : cnt + CW'(1);
                    if (mul_start_c && (state == ST_FMR)) acc_l <= prod;
                    if (mul_start_c && (state == ST_PCM)) acc_r <= prod;
                    if (last_c) begin
                        if (state == ST_FML)      state <= ST_FMR;
                        else if (state == ST_FMR) state <= ST_PCM;
                        else                      state <= ST_SAT;
                    end
                end
                ST_SAT: begin
                    stg_l  <= sat_l_c[15:0];
                    stg_r  <= sat_r_c[15:0];
                    stg_cl <= sat_l_c[16];
                    stg_cr <= sat_r_c[16];
                    stg_v  <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: ;
            endcase

            // Start a sample (fresh strobe wins over the buffered one), or buffer a busy-time strobe.
            if (start_c) begin
                w_fm    <= fm_sample ? fm_pair_t'({fm_left, fm_right}) : p_fm;
                w_fg    <= fm_sample ? fm_gain  : p_fg;
                w_pg    <= fm_sample ? pcm_gain : p_pg;
                w_pcm   <= pcm_sample ? pcm : pcm_hold;
                pending <= 1'b0;
                if (fm_sample && pending) overrun <= 1'b1;
                cnt     <= '0;
                state   <= ST_FML;
            end else if (fm_sample && (state != ST_IDLE)) begin
                p_fm    <= fm_pair_t'({fm_left, fm_right});
                p_fg    <= fm_gain;
                p_pg    <= pcm_gain;
                pending <= 1'b1;
                if (pending) overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snd_mix.sv
// Directed + light random bench for snd_mix with a cycle-stamped output scoreboard.
module tb_snd_mix;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] fm_left = '0, fm_right = '0;
    logic        fm_sample = 1'b0;
    logic [7:0]  pcm = 8'h80;
    logic        pcm_sample = 1'b0;
    logic [3:0]  fm_gain = '0, pcm_gain = '0;
    logic [15:0] ldatasum, rdatasum;
    logic        out_valid, clip_l, clip_r, overrun;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        cl;
        logic        cr;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  m_pcm = 8'h80;

    snd_mix #(.GW(4), .GSH(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fm_left    (fm_left),
        .fm_right   (fm_right),
        .fm_sample  (fm_sample),
        .pcm        (pcm),
        .pcm_sample (pcm_sample),
        .fm_gain    (fm_gain),
        .pcm_gain   (pcm_gain),
        .ldatasum   (ldatasum),
        .rdatasum   (rdatasum),
        .out_valid  (out_valid),
        .clip_l     (clip_l),
        .clip_r     (clip_r),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    endtask

    function automatic int sat(input int v, output logic c);
        c = 1'b0;
        if (v > 32767)  begin c = 1'b1; return 32767;  end
        if (v < -32768) begin c = 1'b1; return -32768; end
        return v;
    endfunction

    function automatic exp_t model(input logic [15:0] fl, input logic [15:0] fr,
                                   input logic [3:0] fg, input logic [3:0] pg,
                                   input logic [7:0] p, input int at);
        exp_t e;
        int   ps, vl, vr;
        ps = (int'(p) - 128) * 256;
        vl = (int'($signed(fl)) * int'(fg) + ps * int'(pg)) >>> 3;
        vr = (int'($signed(fr)) * int'(fg) + ps * int'(pg)) >>> 3;
        vl = sat(vl, e.cl);
        vr = sat(vr, e.cr);
        e.l   = 16'(vl);
        e.r   = 16'(vr);
        e.cyc = at;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pcm_load(input logic [7:0] p);
        pcm = p; pcm_sample = 1'b1; m_pcm = p;
        tick();
        pcm_sample = 1'b0;
    endtask

    // Strobe sampled at the next edge; lat 0 means no output is expected for it.
    task automatic fm_strobe(input logic [15:0] fl, input logic [15:0] fr,
                             input logic [3:0] fg, input logic [3:0] pg, input int lat);
        fm_left = fl; fm_right = fr; fm_gain = fg; pcm_gain = pg; fm_sample = 1'b1;
        if (lat != 0) sb.push_back(model(fl, fr, fg, pg, m_pcm, cyc + 1 + lat));
        tick();
        fm_sample = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        ticks(2);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("out_cycle", 32'(cyc), 32'(e.cyc));
                check("ldatasum", 32'(ldatasum), 32'(e.l));
                check("rdatasum", 32'(rdatasum), 32'(e.r));
                check("clip_l", 32'(clip_l), 32'(e.cl));
                check("clip_r", 32'(clip_r), 32'(e.cr));
            end
        end
    end

    initial begin
        ticks(3);
        rst_n = 1'b1;
        tick();
        check("rst_ldatasum", 32'(ldatasum), 32'h0);
        check("rst_rdatasum", 32'(rdatasum), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_clips", 32'({clip_l, clip_r}), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);

        // Unity gain, silent PCM
        fm_strobe(16'h4000, 16'hC000, 4'd8, 4'd8, 14);
        drain();
        check("unity_single_pulse", 32'(out_valid), 32'h0);

        // Positive saturation on left
        pcm_load(8'hFF);
        fm_strobe(16'h7000, 16'h0000, 4'd15, 4'd8, 14);
        drain();

        // Negative saturation on right, left lands exactly on -32768
        pcm_load(8'h00);
        fm_strobe(16'h0000, 16'h8000, 4'd15, 4'd8, 14);
        drain();
        check("clip_r_held", 32'(clip_r), 32'h1);
        pcm_load(8'h80);
        fm_strobe(16'h0000, 16'h0000, 4'd15, 4'd8, 14);
        drain();

        // Zero gains silence both sources; then odd values exercising arithmetic shift
        pcm_load(8'h90);
        fm_strobe(16'h1234, 16'hEDCC, 4'd0, 4'd0, 14);
        drain();
        pcm_load(8'h80);
        fm_strobe(16'hFFF3, 16'h0007, 4'd1, 4'd5, 14);
        drain();
        pcm_load(8'h81);
        fm_strobe(16'hFFFB, 16'h0007, 4'd3, 4'd5, 14);
        drain();

        for (int i = 0; i < 4; i++) begin
            pcm_load(8'($urandom));
            fm_strobe(16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom), 14);
            drain();
        end

        // Coincident pcm and fm strobes: the new pcm value is used
        pcm = 8'hC0; pcm_sample = 1'b1; m_pcm = 8'hC0;
        fm_strobe(16'h0000, 16'h0000, 4'd8, 4'd8, 14);
        pcm_sample = 1'b0;
        drain();

        // Pending and overrun: strobes at t0, t0+5, t0+9; the middle one is lost
        check("overrun_before", 32'(overrun), 32'h0);
        fm_strobe(16'h1000, 16'h2000, 4'd8, 4'd0, 14);
        ticks(4);
        fm_strobe(16'h5555, 16'h5555, 4'd8, 4'd0, 0);
        ticks(3);
        fm_strobe(16'h0300, 16'hF400, 4'd4, 4'd8, 18);
        drain();
        check("overrun_set", 32'(overrun), 32'h1);

        // Reset in the middle of a sample; pcm_hold must return to silence
        pcm_load(8'h33);
        fm_strobe(16'h7777, 16'h7777, 4'd8, 4'd8, 0);
        ticks(6);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_pcm = 8'h80;
        check("mid_rst_ldatasum", 32'(ldatasum), 32'h0);
        check("mid_rst_rdatasum", 32'(rdatasum), 32'h0);
        check("mid_rst_overrun", 32'(overrun), 32'h0);
        ticks(12);
        fm_strobe(16'h0100, 16'h0000, 4'd8, 4'd8, 14);
        drain();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/snd_mix.md
SND_MIX -- requirements
Module: snd_mix

Interface
REQ-001 SHALL have parameter GW, default 4, gain word width in bits.
REQ-002 SHALL have parameter GSH, default 3, gain fraction bits; a gain of 2^GSH = 8 is unity.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have ports fm_left and fm_right, input, 16 bits each: FM sample, signed two's complement.
REQ-006 SHALL have port fm_sample, input, 1 bit: one-cycle strobe that marks fm_left/fm_right as valid.
REQ-007 SHALL have port pcm, input, 8 bits: PCM sample, unsigned offset binary, 0x80 = silence.
REQ-008 SHALL have port pcm_sample, input, 1 bit: one-cycle strobe that marks pcm as valid.
REQ-009 SHALL have ports fm_gain and pcm_gain, input, GW bits each: unsigned gain, value/2^GSH.
REQ-010 SHALL have ports ldatasum and rdatasum, output, 16 bits each: signed mixed sample; held between updates; these feed the sigma-delta DAC inputs.
REQ-011 SHALL have port out_valid, output, 1 bit: high for one cycle when ldatasum/rdatasum update.
REQ-012 SHALL have ports clip_l and clip_r, output, 1 bit each: high when the current output sample was saturated.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag for a lost FM sample.

Function
REQ-014 SHALL load pcm_hold from pcm on any pcm_sample; pcm_hold is converted to signed as {~pcm[7],pcm[6:0],8'h00}.
REQ-015 SHALL, on fm_sample in IDLE, capture fm_left, fm_right, fm_gain, pcm_gain and pcm_hold into working registers, and enter FML.
  - If pcm_sample coincides with fm_sample, the new pcm value is captured.
REQ-016 SHALL use the FSM IDLE -> FML (4 cycles) -> FMR (4 cycles) -> PCM (4 cycles) -> SAT (1 cycle) -> IDLE, or -> FML when pending is set.
  - Each 4-cycle state performs one serial shift-add multiply, one gain bit per cycle, LSB first.
REQ-017 SHALL compute each channel as L = (fm_left*fm_gain + pcmS*pcm_gain) >>> GSH, where:
  - each product is 20-bit signed;
  - the sum is 21-bit signed;
  - >>> is an arithmetic shift.
REQ-018 SHALL saturate in SAT: values above 32767 become 0x7FFF and values below -32768 become 0x8000; clip_l/clip_r are set to 1 if saturated, else 0.
REQ-019 SHALL update ldatasum, rdatasum, clip_l, clip_r and out_valid at the 14th rising edge after the edge that sampled fm_sample in IDLE.
REQ-020 SHALL treat fm_sample arriving in any non-IDLE state (SAT included) as pending: its fm_left, fm_right and gains are stored in a one-deep pending buffer and pending is set.
REQ-021 SHALL set overrun and overwrite the buffer with the newest data when fm_sample arrives while pending is already set.
REQ-022 SHALL, when leaving SAT with pending set, clear pending and start the pending sample in FML with no IDLE cycle.
  - Back-to-back outputs are then 13 cycles apart.
  - pcm_hold is captured at that transition.
REQ-023 SHALL make a gain of 0 yield a zero contribution from that source; a gain of 8 passes the source through unchanged.

Reset
REQ-024 SHALL, with rst_n low at a clock edge, set:
  - state to IDLE, pending to 0, overrun to 0;
  - ldatasum and rdatasum to 0x0000;
  - out_valid, clip_l and clip_r to 0;
  - pcm_hold to 0x80.
REQ-025 SHALL abandon any in-flight or pending sample on reset and produce no out_valid for it; the first strobe after reset release is processed normally.

Structure
REQ-026 SHALL place the following in a shared package snd_mix_pkg:
  - the FSM state enum;
  - the saturation limits 0x7FFF/0x8000;
  - the product and sum widths (20 and 21 bits).
REQ-027 SHALL implement the serial shift-add multiplier as one sub-module, snd_mix_smul (16-bit signed x GW-bit unsigned), instanced once and time-shared by FML, FMR and PCM.
  - The left and right PCM terms are identical, so PCM computes once and adds to both accumulators.

Verification
REQ-028 SHALL cover unity gain: fm_left=0x4000, fm_right=0xC000, fm_gain=8, pcm_hold=0x80 -> after 14 edges ldatasum=0x4000, rdatasum=0xC000, out_valid a single pulse, clips 0.
REQ-029 SHALL cover positive saturation: fm_left=0x7000, fm_gain=15, pcm=0xFF, pcm_gain=8 -> ldatasum=0x7FFF, clip_l=1.
REQ-030 SHALL cover negative saturation: fm_right=0x8000, fm_gain=15, pcm=0x00, pcm_gain=8 -> rdatasum=0x8000, clip_r=1; next sample with fm_right=0 and pcm=0x80 -> clip_r=0.
REQ-031 SHALL cover pending and overrun: fm_sample at cycles 0, 5, 9 -> out_valid at 14 and 27 (the cycle-9 data), overrun=1, the cycle-5 sample is never output.
REQ-032 SHALL cover reset mid-operation: rst_n low at cycle 7 of a sequence -> no out_valid, outputs 0x0000, pcm_hold=0x80; a strobe at cycle 20 -> out_valid at 34.
REQ-033 SHALL cover pcm/fm coincidence: pcm_sample with pcm=0xC0 and fm_sample in the same cycle, fm=0, pcm_gain=8 -> ldatasum=rdatasum=0x4000.
